fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues in-order requests to an instruction memory that may have latency.
- Buffers returned instructions in a DEPTH-entry FIFO and presents instruction, PC and PC+4 to the datapath over a valid/ready handshake.
- A redirect (branch or jump target) flushes the FIFO and all in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; word aligned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid. Responses arrive in order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle redirect request.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  datapath consumes the head entry.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  head PC.
- dec_pc_plus4  out  32  head PC + 4, modulo 2^32.
- queue_count  out  $clog2(DEPTH)+1  number of valid FIFO entries.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; in-flight=0; discard=0.
  - All outputs 0, except imem_req_addr=RESET_PC.
- Request issue:
  - imem_req_valid=1 when (queue_count + in-flight) < DEPTH and redirect_valid=0.
  - imem_req_addr=fetch_pc.
  - On accept (valid&ready): fetch_pc += 4 (wraps at 2^32); in-flight += 1.
  - Each FIFO entry stores its request address; one PC tag FIFO of DEPTH entries tracks in-flight requests.
  - Once imem_req_valid is high, addr stays stable until accepted or until a redirect arrives.
- Response handling:
  - If discard>0: the response is dropped; discard -= 1; in-flight -= 1.
  - Otherwise: the instruction and its tagged PC are pushed; in-flight -= 1.
  - Credit accounting guarantees no push into a full FIFO. A response arriving with in-flight=0 is a protocol error and is ignored.
- Output:
  - dec_* driven from the FIFO head, registered, zero latency from head.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle are allowed; queue_count is unchanged.
  - Data written into an empty FIFO is visible on dec_* the next cycle (minimum fetch-to-decode latency: response cycle + 1).
- Redirect (redirect_valid=1) takes priority over all other activity:
  - FIFO cleared; queue_count=0 the next cycle; dec_valid=0 the next cycle.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - discard = in-flight, minus 1 if a non-discarded response arrives in the same cycle (that response is dropped).
  - imem_req_valid=0 in the redirect cycle. Fetch resumes the following cycle.
  - A dec handshake in the redirect cycle still counts as consumed.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Wrap-around:
  - Read/write pointers are log2(DEPTH) bits wide and wrap naturally.
  - PC 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset mid-operation: immediate return to reset state. In-flight responses arriving after reset are not discarded; the memory must be reset with this block.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles (32), perf_flushes (16), perf_discards (16).
  - stall counts cycles with dec_valid=0 and rst_n=1.
  - flushes counts redirect cycles.
  - discards counts dropped responses.
  - All counters saturate at their maximum and reset to 0.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset, memory always ready with 1-cycle latency, dec_ready=1 -> requests to 0x0,0x4,0x8,...; dec_pc 0x0 appears 2 cycles after the first accept; dec_pc_plus4=0x4; one instruction per cycle thereafter.
- dec_ready=0, memory always ready -> exactly 4 requests issued; queue_count reaches 4; imem_req_valid stays 0. Raising dec_ready for one cycle -> one new request to 0x10.
- 3 requests in flight (latency 3 cycles), then redirect_pc=0x0000_0103 -> next request addr 0x100; the 3 old responses are dropped; the first dec_pc is 0x100.
- Redirect in the same cycle as a response and a dec handshake -> response dropped; popped entry consumed; queue_count=0 next cycle; no stale instruction ever reaches dec_*.
- redirect_pc=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; dec_pc_plus4 of 0xFFFF_FFFC equals 0x0.
- imem_req_ready held low for 5 cycles -> imem_req_addr stable at the same value; no PC advance. With FETCH_PERF_EN, perf_stall_cycles increments on each empty cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order memory requests and
// buffers responses for decode. Optional perf counters are enabled by FETCH_PERF_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_instr,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_pc_plus4,
  output logic [$clog2(DEPTH):0]   queue_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_stall_cycles,
  output logic [15:0]              perf_flushes,
  output logic [15:0]              perf_discards
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic          run;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   tag_mem   [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0] count, inflight, discard;
  logic [CW:0]   credit_used;
  logic          accept, resp_ok, drop, push, pop;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    credit_used    = {1'b0, count} + {1'b0, inflight};
    imem_req_valid = run && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    accept         = imem_req_valid && imem_req_ready;
    resp_ok        = imem_resp_valid && (inflight != '0);
    drop           = resp_ok && (redirect_valid || (discard != '0));
    push           = resp_ok && !drop;
    pop            = dec_valid && dec_ready;
  end

  assign imem_req_addr = fetch_pc;
  assign queue_count   = count;
  assign dec_valid     = (count != '0);
  assign dec_instr     = dec_valid ? instr_mem[rd_ptr] : '0;
  assign dec_pc        = dec_valid ? pc_mem[rd_ptr] : '0;
  assign dec_pc_plus4  = dec_valid ? pc_mem[rd_ptr] + 32'd4 : '0;

  // run holds off requests for the first cycle out of reset so outputs stay 0 in reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      run      <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight + CW'(accept) - CW'(resp_ok);
      if (accept)  tag_wr <= tag_wr + 1'b1;
      if (resp_ok) tag_rd <= tag_rd + 1'b1;
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        discard  <= inflight - CW'(resp_ok);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (drop)   discard  <= discard - 1'b1;
        if (push)   wr_ptr   <= wr_ptr + 1'b1;
        if (pop)    rd_ptr   <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; dec_* are gated by dec_valid instead.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      instr_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]    <= tag_mem[tag_rd];
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_discards     <= '0;
    end else begin
      if (!dec_valid && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (redirect_valid && (perf_flushes != '1))  perf_flushes      <= perf_flushes + 1'b1;
      if (drop && (perf_discards != '1))           perf_discards     <= perf_discards + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order latency memory model plus a PC
// scoreboard filled on request acceptance and drained on decode handshakes.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;
  logic [2:0]  queue_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flushes, perf_discards;
`endif

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4),
    .queue_count(queue_count)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
    .perf_discards(perf_discards)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int mem_lat = 1;
  int ncyc = 0;
  int n_acc = 0;
  int n_dec = 0;
  int first_acc_n = -1;
  int first_dec_n = -1;
  logic [31:0] first_dec_pc, last_dec_pc, wrap_plus4;
  logic        wrap_seen;
  logic [31:0] sb[$];
  logic [31:0] acc_log[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // One clock: at the falling edge observe handshakes, update the scoreboard and
  // drive the memory response; return just after the next rising edge.
  task automatic cycle();
    logic [31:0] exp;
    @(negedge clk);
    ncyc++;
    if (!rst_n) begin
      sb.delete(); acc_log.delete(); pend_addr.delete(); pend_due.delete();
      n_acc = 0; n_dec = 0; first_acc_n = -1; first_dec_n = -1; wrap_seen = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = '0;
    end else begin
      if (dec_valid && dec_ready) begin
        if (n_dec == 0) begin first_dec_n = ncyc; first_dec_pc = dec_pc; end
        n_dec++;
        last_dec_pc = dec_pc;
        if (dec_pc == 32'hFFFF_FFFC) begin wrap_seen = 1'b1; wrap_plus4 = dec_pc_plus4; end
        checks++;
        if (sb.size() == 0)
          $display("FAIL dec_unexpected: got pc=%h, required no decode output", dec_pc);
        else begin
          exp = sb.pop_front();
          if (dec_pc !== exp || dec_pc_plus4 !== exp + 32'd4 || dec_instr !== instr_of(exp))
            $display("FAIL dec_entry: got pc=%h plus4=%h instr=%h, required pc=%h plus4=%h instr=%h",
                     dec_pc, dec_pc_plus4, dec_instr, exp, exp + 32'd4, instr_of(exp));
          else passed++;
        end
      end
      if (redirect_valid) begin sb.delete(); acc_log.delete(); end
      if (imem_req_valid && imem_req_ready) begin
        if (n_acc == 0) first_acc_n = ncyc;
        n_acc++;
        sb.push_back(imem_req_addr);
        acc_log.push_back(imem_req_addr);
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(ncyc + mem_lat);
      end
      if (pend_due.size() > 0 && pend_due[0] <= ncyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_ready = 1'b0; imem_req_ready = 1'b0;
    #1;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    cycle(); cycle();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0)
      $display("FAIL reset_req: got valid=%b addr=%h, required valid=0 addr=00000000", imem_req_valid, imem_req_addr);
    else passed++;
    checks++;
    if (dec_valid !== 1'b0 || queue_count !== 3'd0)
      $display("FAIL reset_dec: got valid=%b count=%0d, required valid=0 count=0", dec_valid, queue_count);
    else passed++;
    checks++;
    if (dec_pc !== 32'h0 || dec_pc_plus4 !== 32'h0 || dec_instr !== 32'h0)
      $display("FAIL reset_dec_data: got pc=%h plus4=%h instr=%h, required all 0", dec_pc, dec_pc_plus4, dec_instr);
    else passed++;
  endtask

  task automatic test_stream();
    int snap;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 20 && n_dec == 0; i++) cycle();
    checks++;
    if (n_dec == 0) $display("FAIL stream_timeout: got no decode output, required one within 20 cycles");
    else passed++;
    checks++;
    if (first_dec_n - first_acc_n !== 2 || first_dec_pc !== 32'h0)
      $display("FAIL stream_latency: got %0d cycles pc=%h, required 2 cycles pc=00000000",
               first_dec_n - first_acc_n, first_dec_pc);
    else passed++;
    snap = n_dec;
    repeat (20) cycle();
    checks++;
    if (n_dec - snap !== 20) $display("FAIL stream_rate: got %0d decodes, required 20", n_dec - snap);
    else passed++;
    checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8)
      $display("FAIL stream_addrs: got %0d requests starting %h, required 0,4,8", acc_log.size(), acc_log[0]);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; dec_ready = 1'b0;
    repeat (12) cycle();
    checks++;
    if (n_acc !== 4 || queue_count !== 3'd4 || imem_req_valid !== 1'b0)
      $display("FAIL bp_full: got reqs=%0d count=%0d valid=%b, required reqs=4 count=4 valid=0",
               n_acc, queue_count, imem_req_valid);
    else passed++;
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10 || queue_count !== 3'd3)
      $display("FAIL bp_release: got valid=%b addr=%h count=%0d, required valid=1 addr=00000010 count=3",
               imem_req_valid, imem_req_addr, queue_count);
    else passed++;
    repeat (4) cycle();
    checks++;
    if (n_acc !== 5 || queue_count !== 3'd4 || acc_log[4] !== 32'h10)
      $display("FAIL bp_refill: got reqs=%0d count=%0d, required reqs=5 count=4", n_acc, queue_count);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (queue_count !== 3'd0 || dec_valid !== 1'b0 || imem_req_addr !== 32'h0)
      $display("FAIL midop_reset: got count=%0d valid=%b addr=%h, required 0 0 00000000",
               queue_count, dec_valid, imem_req_addr);
    else passed++;
  endtask

  task automatic test_redirect_inflight();
    int snap;
    do_reset();
    mem_lat = 3; imem_req_ready = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc < 3; i++) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) $display("FAIL redir_req_block: got valid=%b, required 0", imem_req_valid);
    else passed++;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)
      $display("FAIL redir_addr: got valid=%b addr=%h, required valid=1 addr=00000100", imem_req_valid, imem_req_addr);
    else passed++;
    snap = n_dec;
    for (int i = 0; i < 30 && n_dec == snap; i++) cycle();
    checks++;
    if (n_dec == snap || last_dec_pc !== 32'h100)
      $display("FAIL redir_first_pc: got pc=%h, required 00000100", last_dec_pc);
    else passed++;
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_discards !== 16'd3 || perf_flushes !== 16'd1)
      $display("FAIL perf_redirect: got discards=%0d flushes=%0d, required 3 1", perf_discards, perf_flushes);
    else passed++;
`endif
  endtask

  task automatic test_redirect_collision();
    int snap;
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b1; dec_ready = 1'b1;
    repeat (8) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    #1;
    checks++;
    if (dec_valid !== 1'b1) $display("FAIL collide_setup: got dec_valid=%b, required 1", dec_valid);
    else passed++;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (queue_count !== 3'd0 || dec_valid !== 1'b0)
      $display("FAIL collide_flush: got count=%0d valid=%b, required 0 0", queue_count, dec_valid);
    else passed++;
    snap = n_dec;
    for (int i = 0; i < 30 && n_dec == snap; i++) cycle();
    checks++;
    if (n_dec == snap || last_dec_pc !== 32'h2000)
      $display("FAIL collide_first_pc: got pc=%h, required 00002000", last_dec_pc);
    else passed++;
    repeat (10) cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat = 2; imem_req_ready = 1'b1; dec_ready = 1'b1;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 30 && !(wrap_seen && acc_log.size() >= 3); i++) cycle();
    checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'hFFFF_FFF8 || acc_log[1] !== 32'hFFFF_FFFC || acc_log[2] !== 32'h0)
      $display("FAIL wrap_addrs: got %0d requests starting %h, required FFFFFFF8,FFFFFFFC,00000000",
               acc_log.size(), acc_log[0]);
    else passed++;
    checks++;
    if (!wrap_seen || wrap_plus4 !== 32'h0)
      $display("FAIL wrap_plus4: got seen=%b plus4=%h, required seen=1 plus4=00000000", wrap_seen, wrap_plus4);
    else passed++;
  endtask

  task automatic test_stall();
`ifdef FETCH_PERF_EN
    logic [31:0] stall_snap;
`endif
    do_reset();
    mem_lat = 1; imem_req_ready = 1'b0; dec_ready = 1'b1;
    cycle(); cycle();
`ifdef FETCH_PERF_EN
    stall_snap = perf_stall_cycles;
`endif
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
        $display("FAIL stall_hold%0d: got valid=%b addr=%h, required valid=1 addr=00000000",
                 i, imem_req_valid, imem_req_addr);
      else passed++;
    end
    checks++;
    if (n_acc !== 0) $display("FAIL stall_noaccept: got %0d accepts, required 0", n_acc);
    else passed++;
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_stall_cycles - stall_snap !== 32'd5)
      $display("FAIL perf_stall: got %0d, required 5", perf_stall_cycles - stall_snap);
    else passed++;
`endif
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && n_dec == 0; i++) cycle();
    checks++;
    if (n_dec == 0 || first_dec_pc !== 32'h0)
      $display("FAIL stall_resume: got decodes=%0d pc=%h, required first pc=00000000", n_dec, first_dec_pc);
    else passed++;
  endtask

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    wrap_seen       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap();
    test_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
